// File: rtl/axi_wr_txn_sched_if.sv
// Bus bundle for the four-master write-path scheduler: master-side AW/W/B
// qualifiers, slave-side ready/valid, and the scheduler's routing outputs.
interface axi_wr_txn_sched_if #(
  parameter int LEN_W = 8
);
  logic [3:0]         m_awvalid;
  logic [4*LEN_W-1:0] m_awlen;
  logic               s_awready;
  logic [3:0]         m_wvalid;
  logic [3:0]         m_wlast;
  logic               s_wready;
  logic               s_bvalid;
  logic [3:0]         m_bready;
  logic [3:0]         grant;
  logic               aw_en;
  logic               w_en;
  logic               b_en;
  logic [LEN_W-1:0]   beat_cnt;
  logic               wlast_err;
  logic               timeout;
  logic               busy;

  modport slave (
    input  m_awvalid, m_awlen, s_awready, m_wvalid, m_wlast, s_wready,
           s_bvalid, m_bready,
    output grant, aw_en, w_en, b_en, beat_cnt, wlast_err, timeout, busy
  );

  modport master (
    output m_awvalid, m_awlen, s_awready, m_wvalid, m_wlast, s_wready,
           s_bvalid, m_bready,
    input  grant, aw_en, w_en, b_en, beat_cnt, wlast_err, timeout, busy
  );
endinterface

// File: rtl/axi_wr_txn_sched.sv
// Round-robin write-transaction scheduler: grants one of four masters the
// AW->W->B path for a whole burst, with per-phase idle timeout.
module axi_wr_txn_sched #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int LEN_W       = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axi_wr_txn_sched_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYC - 1);

  state_t           r_state;
  logic [1:0]       r_owner;
  logic [1:0]       r_last_owner;
  logic [3:0]       r_grant;
  logic             r_aw_en;
  logic             r_w_en;
  logic             r_b_en;
  logic [LEN_W-1:0] r_len_q;
  logic [LEN_W-1:0] r_beat_cnt;
  logic [15:0]      r_timer;
  logic             r_wlast_err;
  logic             r_timeout;
  logic             r_busy;

  logic [1:0]       w_pick;
  logic [LEN_W-1:0] w_awlen;
  logic             w_final;
  logic             w_hs;
  logic             w_expire;

  // First requester at or after last+1, wrapping; last itself is tried last.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    f_rr_pick = 2'd0;
    found     = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        f_rr_pick = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign w_pick   = f_rr_pick(bus.m_awvalid, r_last_owner);
  assign w_awlen  = bus.m_awlen[LEN_W*int'(r_owner) +: LEN_W];
  assign w_final  = (r_beat_cnt == r_len_q);
  assign w_expire = (r_timer == TMAX);

  always_comb begin
    w_hs = 1'b0;
    case (r_state)
      S_ADDR:  w_hs = bus.m_awvalid[r_owner] && bus.s_awready;
      S_DATA:  w_hs = bus.m_wvalid[r_owner] && bus.s_wready;
      S_RESP:  w_hs = bus.s_bvalid && bus.m_bready[r_owner];
      default: w_hs = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_owner      <= 2'd0;
      r_last_owner <= 2'd3;
      r_grant      <= 4'd0;
      r_aw_en      <= 1'b0;
      r_w_en       <= 1'b0;
      r_b_en       <= 1'b0;
      r_len_q      <= '0;
      r_beat_cnt   <= '0;
      r_timer      <= 16'd0;
      r_wlast_err  <= 1'b0;
      r_timeout    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_wlast_err <= 1'b0;
      r_timeout   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (|bus.m_awvalid) begin
          r_owner <= w_pick;
          r_grant <= 4'b0001 << w_pick;
          r_aw_en <= 1'b1;
          r_busy  <= 1'b1;
          r_timer <= 16'd0;
          r_state <= S_ADDR;
        end
      end else if (w_hs) begin
        // A handshake on the expiry edge wins over the abort below.
        r_timer <= 16'd0;
        case (r_state)
          S_ADDR: begin
            r_len_q    <= w_awlen;
            r_beat_cnt <= '0;
            r_aw_en    <= 1'b0;
            r_w_en     <= 1'b1;
            r_state    <= S_DATA;
          end
          S_DATA: begin
            r_wlast_err <= (bus.m_wlast[r_owner] != w_final);
            if (w_final) begin
              r_w_en  <= 1'b0;
              r_b_en  <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
          end
          S_RESP: begin
            r_last_owner <= r_owner;
            r_grant      <= 4'd0;
            r_b_en       <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
          default: ;
        endcase
      end else if (w_expire) begin
        r_timeout    <= 1'b1;
        r_last_owner <= r_owner;
        r_grant      <= 4'd0;
        r_aw_en      <= 1'b0;
        r_w_en       <= 1'b0;
        r_b_en       <= 1'b0;
        r_busy       <= 1'b0;
        r_timer      <= 16'd0;
        r_state      <= S_IDLE;
      end else begin
        r_timer <= r_timer + 16'd1;
      end
    end
  end

  assign bus.grant     = r_grant;
  assign bus.aw_en     = r_aw_en;
  assign bus.w_en      = r_w_en;
  assign bus.b_en      = r_b_en;
  assign bus.beat_cnt  = r_beat_cnt;
  assign bus.wlast_err = r_wlast_err;
  assign bus.timeout   = r_timeout;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_axi_wr_txn_sched.sv
// Directed bench for axi_wr_txn_sched: expected values are queued as each
// step is driven and popped in order when the outputs are sampled.
module tb_axi_wr_txn_sched;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  string       sb_tag[$];
  logic [31:0] sb_exp[$];

  axi_wr_txn_sched_if #(.LEN_W(8)) bus ();

  axi_wr_txn_sched #(.TIMEOUT_CYC(8), .LEN_W(8)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] e);
    sb_tag.push_back(tag);
    sb_exp.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] e;
    total++;
    if (sb_exp.size() == 0) begin
      bad++;
      $error("FAIL sb_empty got=%0h", obs);
    end else begin
      tag = sb_tag.pop_front();
      e   = sb_exp.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s got=%0h exp=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle_inputs();
    bus.m_awvalid = 4'b0000;
    bus.m_awlen   = 32'h0;
    bus.s_awready = 1'b0;
    bus.m_wvalid  = 4'b0000;
    bus.m_wlast   = 4'b0000;
    bus.s_wready  = 1'b0;
    bus.s_bvalid  = 1'b0;
    bus.m_bready  = 4'b0000;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle_inputs();
    step();
    step();

    // Reset state
    push("rst_grant", 32'h0); push("rst_busy", 32'h0);
    push("rst_beat", 32'h0);  push("rst_tmo", 32'h0);
    pop_chk(32'(bus.grant)); pop_chk(32'(bus.busy));
    pop_chk(32'(bus.beat_cnt)); pop_chk(32'(bus.timeout));

    // First arbitration after reset: 1010 -> master 1
    rst = 1'b0;
    bus.m_awvalid = 4'b1010;
    bus.m_awlen   = 32'h0000_0300;
    push("arb1_grant", 32'h2); push("arb1_aw_en", 32'h1); push("arb1_busy", 32'h1);
    step();
    pop_chk(32'(bus.grant)); pop_chk(32'(bus.aw_en)); pop_chk(32'(bus.busy));

    // AW handshake, master 3 still requesting must be ignored
    bus.s_awready = 1'b1;
    push("aw_hs_w_en", 32'h1); push("aw_hs_aw_en", 32'h0);
    push("aw_hs_beat", 32'h0); push("aw_hs_grant", 32'h2);
    step();
    pop_chk(32'(bus.w_en)); pop_chk(32'(bus.aw_en));
    pop_chk(32'(bus.beat_cnt)); pop_chk(32'(bus.grant));
    bus.s_awready = 1'b0;
    bus.m_awvalid = 4'b0000;

    // Four beats, WLAST on beat 4
    bus.s_wready = 1'b1;
    bus.m_wvalid = 4'b0010;
    for (int b = 1; b <= 4; b++) begin
      bus.m_wlast = (b == 4) ? 4'b0010 : 4'b0000;
      push("burst_beat", (b < 4) ? 32'(b) : 32'h3);
      push("burst_werr", 32'h0);
      push("burst_b_en", (b < 4) ? 32'h0 : 32'h1);
      step();
      pop_chk(32'(bus.beat_cnt)); pop_chk(32'(bus.wlast_err)); pop_chk(32'(bus.b_en));
    end
    bus.m_wvalid = 4'b0000;
    bus.m_wlast  = 4'b0000;

    // B handshake; new request 1011 waits for the idle bubble
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 4'b0010;
    bus.m_awvalid = 4'b1011;
    bus.m_awlen   = 32'h0100_0000;
    push("bubble_grant", 32'h0); push("bubble_busy", 32'h0); push("resp_beat_hold", 32'h3);
    step();
    pop_chk(32'(bus.grant)); pop_chk(32'(bus.busy)); pop_chk(32'(bus.beat_cnt));
    bus.s_bvalid = 1'b0;
    bus.m_bready = 4'b0000;
    push("arb2_grant", 32'h8);
    step();
    pop_chk(32'(bus.grant));

    // Master 3, awlen=1, WLAST early on beat 1
    bus.s_awready = 1'b1;
    push("m3_aw_beat", 32'h0);
    step();
    pop_chk(32'(bus.beat_cnt));
    bus.s_awready = 1'b0;
    bus.m_awvalid = 4'b0000;
    bus.m_wvalid  = 4'b1000;
    bus.m_wlast   = 4'b1000;
    push("early_werr1", 32'h1); push("early_beat1", 32'h1); push("early_w_en1", 32'h1);
    step();
    pop_chk(32'(bus.wlast_err)); pop_chk(32'(bus.beat_cnt)); pop_chk(32'(bus.w_en));
    bus.m_wlast = 4'b0000;
    push("early_werr2", 32'h1); push("early_b_en2", 32'h1); push("early_beat2", 32'h1);
    step();
    pop_chk(32'(bus.wlast_err)); pop_chk(32'(bus.b_en)); pop_chk(32'(bus.beat_cnt));
    bus.m_wvalid = 4'b0000;
    push("werr_clear", 32'h0);
    step();
    pop_chk(32'(bus.wlast_err));
    bus.s_bvalid = 1'b1;
    bus.m_bready = 4'b1000;
    push("m3_done_grant", 32'h0);
    step();
    pop_chk(32'(bus.grant));
    bus.s_bvalid = 1'b0;
    bus.m_bready = 4'b0000;

    // Timeout in DATA: master 0 never sends WVALID
    bus.m_awvalid = 4'b0001;
    push("tmo_grant", 32'h1);
    step();
    pop_chk(32'(bus.grant));
    bus.s_awready = 1'b1;
    push("tmo_data_w_en", 32'h1);
    step();
    pop_chk(32'(bus.w_en));
    bus.s_awready = 1'b0;
    bus.m_awvalid = 4'b0000;
    for (int c = 1; c <= 7; c++) step();
    push("tmo_early", 32'h0); push("tmo_early_w_en", 32'h1);
    pop_chk(32'(bus.timeout)); pop_chk(32'(bus.w_en));
    push("tmo_pulse", 32'h1); push("tmo_grant0", 32'h0);
    push("tmo_busy0", 32'h0); push("tmo_w_en0", 32'h0);
    step();
    pop_chk(32'(bus.timeout)); pop_chk(32'(bus.grant));
    pop_chk(32'(bus.busy)); pop_chk(32'(bus.w_en));
    push("tmo_one_cycle", 32'h0);
    step();
    pop_chk(32'(bus.timeout));

    // Reset mid-DATA with beat_cnt=2; last owner 0 so 0100 -> master 2
    bus.m_awvalid = 4'b0100;
    bus.m_awlen   = 32'h0004_0000;
    push("r_grant", 32'h4);
    step();
    pop_chk(32'(bus.grant));
    bus.s_awready = 1'b1;
    step();
    bus.s_awready = 1'b0;
    bus.m_awvalid = 4'b0000;
    bus.s_wready  = 1'b1;
    bus.m_wvalid  = 4'b0100;
    step();
    step();
    bus.m_wvalid = 4'b0000;
    push("r_pre_beat", 32'h2);
    pop_chk(32'(bus.beat_cnt));
    rst = 1'b1;
    push("r_grant0", 32'h0); push("r_beat0", 32'h0);
    push("r_busy0", 32'h0); push("r_w_en0", 32'h0);
    step();
    pop_chk(32'(bus.grant)); pop_chk(32'(bus.beat_cnt));
    pop_chk(32'(bus.busy)); pop_chk(32'(bus.w_en));

    // All four requesting continuously: 0,1,2,3,0 with a bubble each
    bus.m_awvalid = 4'b1111;
    bus.m_awlen   = 32'h0;
    bus.s_awready = 1'b1;
    bus.m_wvalid  = 4'b1111;
    bus.m_wlast   = 4'b1111;
    bus.s_wready  = 1'b1;
    bus.s_bvalid  = 1'b1;
    bus.m_bready  = 4'b1111;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      push("rr_grant", 32'(4'b0001 << (t % 4)));
      step();
      pop_chk(32'(bus.grant));
      step();
      step();
      push("rr_werr", 32'h0);
      pop_chk(32'(bus.wlast_err));
      push("rr_bubble", 32'h0);
      step();
      pop_chk(32'(bus.grant));
    end
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_wr_txn_sched.md
AXI_WR_TXN_SCHED -- requirements
Module: axi_wr_txn_sched

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1024, maximum idle cycles per phase before abort; legal range 2..65535.
REQ-002 Parameter LEN_W, default 8, AWLEN width; burst beats = AWLEN+1.
REQ-003 Clock, reset and all ports SHALL be:
- ACLK  in  1  single clock; all logic on its rising edge.
- ARESET  in  1  reset; synchronous, active-high.
- m_awvalid  in  4  AWVALID of masters 0..3.
- m_awlen  in  4*LEN_W  AWLEN; master i at [LEN_W*i +: LEN_W].
- s_awready  in  1  AWREADY of the addressed slave.
- m_wvalid  in  4  WVALID of masters 0..3.
- m_wlast  in  4  WLAST of masters 0..3.
- s_wready  in  1  WREADY of the slave.
- s_bvalid  in  1  BVALID of the slave.
- m_bready  in  4  BREADY of masters 0..3.
- grant  out  4  one-hot owner of the write path; 0 when idle.
- aw_en  out  1  route AW channel of grant owner.
- w_en  out  1  route W channel of grant owner.
- b_en  out  1  route B channel to grant owner.
- beat_cnt  out  LEN_W  W beats accepted in current burst.
- wlast_err  out  1  one-cycle pulse, WLAST misplaced.
- timeout  out  1  one-cycle pulse, phase aborted.
- busy  out  1  state != IDLE.

Function
REQ-004 FSM states SHALL be IDLE, ADDR, DATA, RESP; all outputs registered.
REQ-005 IDLE: grant=0, aw_en=w_en=b_en=0; if any m_awvalid bit set at edge N, SHALL select the first requester in round-robin order starting at last_owner+1 (mod 4), assert grant and aw_en from edge N+1, enter ADDR.
REQ-006 ADDR: aw_en=1; on m_awvalid[g] && s_awready SHALL latch m_awawlen of owner g into len_q, clear beat_cnt, enter DATA next cycle (aw_en=0, w_en=1).
REQ-007 DATA: each m_wvalid[g] && s_wready SHALL increment beat_cnt by 1.
REQ-008 DATA: beat with beat_cnt==len_q SHALL be the final beat; FSM enters RESP next cycle (w_en=0, b_en=1) regardless of WLAST.
REQ-009 wlast_err SHALL pulse the cycle after any accepted beat where m_wlast[g] != (beat_cnt==len_q); no state change beyond REQ-008.
REQ-010 beat_cnt SHALL never wrap within a burst (max value len_q); it holds its value in RESP and clears on next ADDR handshake.
REQ-011 RESP: on s_bvalid && m_bready[g] SHALL set last_owner=g, return to IDLE next cycle with grant=0 (one idle bubble between transactions).
REQ-012 Phase timer SHALL clear on state entry and on every handshake of the active phase, otherwise increment in ADDR/DATA/RESP.
REQ-013 When timer reaches TIMEOUT_CYC-1 without handshake, timeout SHALL pulse one cycle, last_owner=g, FSM returns to IDLE, all enables 0 on the same edge.
REQ-014 Handshake on the timer-expiry edge SHALL take precedence over timeout.
REQ-015 Requests from non-owners SHALL be ignored until IDLE; owner dropping m_awvalid in ADDR is resolved only by timeout.
REQ-016 grant SHALL be one-hot or zero at every cycle; aw_en, w_en, b_en mutually exclusive.

Reset
REQ-017 ARESET high at an edge SHALL force state=IDLE, last_owner=3 (master 0 highest priority first), grant=0, all enables 0, beat_cnt=0, len_q=0, timer=0, wlast_err=0, timeout=0, busy=0 from that edge, including mid-transaction.
REQ-018 First arbitration SHALL occur on the first edge with ARESET low.

Verification
REQ-019 Benches SHALL cover:
- After reset, m_awvalid=4'b1010 at edge N -> grant=4'b0010, aw_en=1 at N+1.
- Master 1 burst awlen=3, WLAST on beat 4, B accepted -> beat_cnt 0..3, wlast_err=0, grant=0 one cycle later; m_awvalid=4'b1011 then -> grant=4'b1000.
- awlen=1, WLAST on beat 1 -> wlast_err pulses after beat 1 and after beat 2; RESP entered after beat 2.
- TIMEOUT_CYC=8, owner never asserts WVALID -> timeout pulse 8 cycles after DATA entry, IDLE next, grant=0.
- All four masters requesting continuously -> grants 0,1,2,3,0 in order.
- ARESET asserted in DATA with beat_cnt=2 -> next edge grant=0, beat_cnt=0, busy=0.
